btn_debounce: RTL and testbench

Conditions the five raw board push-buttons (centre, up, down, left, right) before they reach the button-to-joystick mapping stage. Each button is brought into the `clk_peripheral` domain through a two-flop synchroniser and then filtered by a per-channel stability counter. The block outputs clean levels plus single-cycle press and release strobes. It sits directly upstream of `btn_jstk`, which consumes `btn_state` unchanged.

---
 rtl/btn_debounce_pkg.sv | 19 +
 rtl/btn_debounce_ch.sv | 82 ++++++++
 rtl/btn_debounce.sv | 30 +++
 tb/tb_btn_debounce.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/btn_debounce_pkg.sv
// Shared push-button constants: bit index of each board button inside the
// NUM_BTN-wide vectors, the default filter length and the filter state type.
package btn_debounce_pkg;

    localparam int BTN_C = 4;
    localparam int BTN_U = 3;
    localparam int BTN_D = 2;
    localparam int BTN_L = 1;
    localparam int BTN_R = 0;

    // 10 ms at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } filt_state_e;

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounced channel: two-flop synchroniser, stability counter, stable
// level and registered press/release strobes for a single asynchronous bit.
module btn_debounce_ch
    import btn_debounce_pkg::*;
#(
    parameter  int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             press_q;
    logic             rel_q;

    filt_state_e      state;
    logic             stable_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             press_nxt;
    logic             rel_nxt;

    // The filter state is implied by whether the synchronised input
    // disagrees with the accepted level; it needs no register of its own.
    always_comb begin
        state      = (sync2 == stable) ? ST_STABLE : ST_PENDING;
        stable_nxt = stable;
        cnt_nxt    = '0;
        press_nxt  = 1'b0;
        rel_nxt    = 1'b0;
        case (state)
            ST_STABLE: begin
                cnt_nxt = '0;
            end
            ST_PENDING: begin
                if (cnt == CNT_MAX) begin
                    stable_nxt = sync2;
                    cnt_nxt    = '0;
                    press_nxt  = sync2;
                    rel_nxt    = ~sync2;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            stable  <= 1'b0;
            cnt     <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            stable  <= stable_nxt;
            cnt     <= cnt_nxt;
            press_q <= press_nxt;
            rel_q   <= rel_nxt;
        end
    end

    assign level = stable;
    assign press = press_q;
    assign rel   = rel_q;

endmodule

// File: rtl/btn_debounce.sv
// Debounces the five board push-buttons {btnc, btnu, btnd, btnl, btnr} into
// clean levels plus one-cycle press/release strobes for btn_jstk.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int NUM_BTN         = 5,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic               clk_peripheral,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_state,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk   (clk_peripheral),
            .reset (reset),
            .raw   (btn_raw[i]),
            .level (btn_state[i]),
            .press (btn_press[i]),
            .rel   (btn_release[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce with a short filter: directed vector table plus
// randomized bouncing inputs checked against a sliding-window reference model.
module tb_btn_debounce;
    import btn_debounce_pkg::*;

    localparam int NB = 5;
    localparam int DC = 4;

    localparam logic [NB-1:0] C = NB'(1 << BTN_C);
    localparam logic [NB-1:0] U = NB'(1 << BTN_U);
    localparam logic [NB-1:0] D = NB'(1 << BTN_D);
    localparam logic [NB-1:0] L = NB'(1 << BTN_L);
    localparam logic [NB-1:0] R = NB'(1 << BTN_R);
    localparam logic [NB-1:0] Z = '0;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_state;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;

    int checks = 0;
    int errors = 0;

    btn_debounce #(
        .NUM_BTN(NB),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk_peripheral (clk),
        .reset          (reset),
        .btn_raw        (btn_raw),
        .btn_state      (btn_state),
        .btn_press      (btn_press),
        .btn_release    (btn_release)
    );

    always #5 clk = ~clk;

    // Reference model: a change is accepted once the last DC synchronised
    // samples all disagree with the accepted level.
    logic [NB-1:0] m_s1 = '0;
    logic [NB-1:0] m_s2 = '0;
    logic [NB-1:0] m_st = '0;
    logic [NB-1:0] m_pr = '0;
    logic [NB-1:0] m_rl = '0;
    logic [NB-1:0] win[$];

    always @(posedge clk) begin
        if (!reset) begin
            m_s1 = '0;
            m_s2 = '0;
            m_st = '0;
            m_pr = '0;
            m_rl = '0;
            win.delete();
        end else begin
            win.push_back(m_s2);
            if (win.size() > DC) void'(win.pop_front());
            m_pr = '0;
            m_rl = '0;
            for (int i = 0; i < NB; i++) begin
                bit all_diff;
                all_diff = (win.size() == DC);
                foreach (win[k]) if (win[k][i] == m_st[i]) all_diff = 1'b0;
                if (all_diff) begin
                    m_st[i] = ~m_st[i];
                    if (m_st[i]) m_pr[i] = 1'b1;
                    else         m_rl[i] = 1'b1;
                end
            end
            m_s2 = m_s1;
            m_s1 = btn_raw;
        end
    end

    task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step(input logic [NB-1:0] raw, input logic rst_n);
        btn_raw = raw;
        reset   = rst_n;
        @(posedge clk);
        #2;
    endtask

    task automatic cmp_model(input string tag);
        check({tag, " model state"},   btn_state,   m_st);
        check({tag, " model press"},   btn_press,   m_pr);
        check({tag, " model release"}, btn_release, m_rl);
        check({tag, " press&release"}, btn_press & btn_release, Z);
    endtask

    typedef struct {
        logic [NB-1:0] raw;
        logic          rst;
        logic [NB-1:0] st;
        logic [NB-1:0] pr;
        logic [NB-1:0] rl;
    } vec_t;

    vec_t tbl[$];

    task automatic add_v(input logic [NB-1:0] raw, input logic rst,
                         input logic [NB-1:0] st, input logic [NB-1:0] pr,
                         input logic [NB-1:0] rl);
        vec_t v;
        v.raw = raw; v.rst = rst; v.st = st; v.pr = pr; v.rl = rl;
        tbl.push_back(v);
    endtask

    // Hold raw for n cycles; the change lands at index acc (-1 for none).
    task automatic add_seq(input logic [NB-1:0] raw, input int n,
                           input logic [NB-1:0] st_before, input logic [NB-1:0] st_after,
                           input int acc, input logic [NB-1:0] pr, input logic [NB-1:0] rl);
        for (int k = 0; k < n; k++) begin
            if (acc < 0 || k < acc) add_v(raw, 1'b1, st_before, Z, Z);
            else if (k == acc)      add_v(raw, 1'b1, st_after, pr, rl);
            else                    add_v(raw, 1'b1, st_after, Z, Z);
        end
    endtask

    initial begin
        int hold[NB];
        logic [NB-1:0] r;

        // reset, then 20 quiet cycles
        for (int k = 0; k < 3; k++) add_v(Z, 1'b0, Z, Z, Z);
        add_seq(Z, 20, Z, Z, -1, Z, Z);
        // btnc clean press and release
        add_seq(C, 8, Z, C, 5, C, Z);
        add_seq(Z, 8, C, Z, 5, Z, C);
        // btnu bouncing, then held
        for (int k = 0; k < 2; k++) begin
            add_seq(U, 2, Z, Z, -1, Z, Z);
            add_seq(Z, 2, Z, Z, -1, Z, Z);
        end
        add_seq(U, 8, Z, U, 5, U, Z);
        add_seq(Z, 8, U, Z, 5, Z, U);
        // btnl and btnr together
        add_seq(L | R, 8, Z, L | R, 5, L | R, Z);
        add_seq(Z, 8, L | R, Z, 5, Z, L | R);
        // btnd held, reset pulsed at filter count 2
        for (int k = 0; k < 4; k++) add_v(D, 1'b1, Z, Z, Z);
        add_v(D, 1'b0, Z, Z, Z);
        add_seq(D, 8, Z, D, 5, D, Z);
        add_seq(Z, 8, D, Z, 5, Z, D);
        // 3-cycle glitch on btnr: nothing
        for (int k = 0; k < 3; k++) add_v(R, 1'b1, Z, Z, Z);
        add_seq(Z, 8, Z, Z, -1, Z, Z);
        // 4-cycle pulse on btnr: press, then release 6 edges after the fall
        for (int k = 0; k < 4; k++) add_v(R, 1'b1, Z, Z, Z);
        add_v(Z, 1'b1, Z, Z, Z);
        add_v(Z, 1'b1, R, R, Z);
        for (int k = 0; k < 3; k++) add_v(Z, 1'b1, R, Z, Z);
        add_v(Z, 1'b1, Z, Z, R);
        add_seq(Z, 2, Z, Z, -1, Z, Z);

        foreach (tbl[i]) begin
            step(tbl[i].raw, tbl[i].rst);
            check($sformatf("vec%0d state", i),   btn_state,   tbl[i].st);
            check($sformatf("vec%0d press", i),   btn_press,   tbl[i].pr);
            check($sformatf("vec%0d release", i), btn_release, tbl[i].rl);
            cmp_model($sformatf("vec%0d", i));
        end

        // randomized bouncing with occasional reset pulses
        r = '0;
        foreach (hold[i]) hold[i] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NB; i++) begin
                if (hold[i] == 0) begin
                    r[i]    = ~r[i];
                    hold[i] = $urandom_range(1, 2 * DC + 2);
                end
                hold[i]--;
            end
            step(r, ($urandom_range(0, 299) != 0));
            cmp_model($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
